router_port_rx: RTL and testbench

//  Packet sink for one 1x3 router output port: drains the port FIFO via vld_out/read_enb,

---
 rtl/router_port_rx.sv | 179 +++++++++++++++++
 tb/tb_router_port_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/router_port_rx.sv
// Router output-port sink: pops the port FIFO, parses the header, streams the payload and checks parity.
// Latency: FIFO read data is captured one cycle after read_enb; a payload byte reaches m_valid the cycle after capture.
// Backpressure: m_ready low holds the skid buffer, and FIFO reads stop once buffered plus in-flight bytes reach BUF_DEPTH.
module router_port_rx #(
    parameter int BUF_DEPTH = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       pkt_done,
    output logic [1:0] pkt_dest,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       trunc_err
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_PARITY,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic          run_en;
    logic          rd_pend;
    logic [6:0]    issued;
    logic [5:0]    rcv_cnt;
    logic [7:0]    par;
    logic [TW-1:0] idle_cnt;
    logic [8:0]    mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] buf_count;

    logic busy, credit_ok, timeout_hit, issue_allowed;
    logic hdr_cap, push, push_last, par_cap, abort, pop;

    assign busy        = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_PARITY);
    assign credit_ok   = (32'(buf_count) + 32'(rd_pend)) < BUF_DEPTH;
    assign timeout_hit = busy && !rd_pend && (idle_cnt == TW'(TIMEOUT - 1));

    // The cycle that aborts must not launch a read whose data would land after the packet is gone.
    assign issue_allowed = run_en &&
                           ((state == S_IDLE) ||
                            (((state == S_PAYLOAD) || (state == S_PARITY)) &&
                             (issued < ({1'b0, pkt_len} + 7'd1)) && !timeout_hit));

    assign read_enb  = vld_out && issue_allowed && credit_ok;
    assign push_last = ((rcv_cnt + 6'd1) == pkt_len);
    assign pop       = m_valid && m_ready;

    assign m_valid = (buf_count != '0);
    assign m_data  = mem[rd_ptr][7:0];
    assign m_last  = m_valid && mem[rd_ptr][8];

    always_comb begin
        state_nx = state;
        hdr_cap  = 1'b0;
        push     = 1'b0;
        par_cap  = 1'b0;
        abort    = 1'b0;
        case (state)
            S_IDLE: begin
                if (read_enb) state_nx = S_HDR;
            end
            S_HDR: begin
                if (rd_pend) begin
                    hdr_cap  = 1'b1;
                    state_nx = (data_out[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_PAYLOAD: begin
                if (rd_pend) begin
                    push = 1'b1;
                    if (push_last) state_nx = S_PARITY;
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_PARITY: begin
                if (rd_pend) begin
                    par_cap  = 1'b1;
                    state_nx = S_DONE;
                end else if (timeout_hit) begin
                    abort    = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            run_en     <= 1'b0;
            rd_pend    <= 1'b0;
            issued     <= '0;
            rcv_cnt    <= '0;
            par        <= '0;
            idle_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            buf_count  <= '0;
            pkt_done   <= 1'b0;
            pkt_dest   <= '0;
            pkt_len    <= '0;
            parity_err <= 1'b0;
            trunc_err  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            state   <= state_nx;
            run_en  <= 1'b1;
            rd_pend <= read_enb;

            if (read_enb) issued <= issued + 7'd1;

            if (busy && !rd_pend) idle_cnt <= idle_cnt + TW'(1);
            else                  idle_cnt <= '0;

            if (hdr_cap) begin
                pkt_len  <= data_out[7:2];
                pkt_dest <= data_out[1:0];
                par      <= data_out;
                issued   <= '0;
                rcv_cnt  <= '0;
            end

            if (push) begin
                par          <= par ^ data_out;
                rcv_cnt      <= rcv_cnt + 6'd1;
                mem[wr_ptr]  <= {push_last, data_out};
                wr_ptr       <= wr_ptr + PW'(1);
            end

            // A truncated packet still needs a stream delimiter on whatever payload is left unread.
            if (abort && (buf_count != '0) && !(pop && (buf_count == CW'(1))))
                mem[wr_ptr - PW'(1)][8] <= 1'b1;

            if (pop) rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase

            pkt_done <= par_cap || abort;
            if (par_cap) begin
                parity_err <= (data_out != par);
                trunc_err  <= 1'b0;
            end else if (abort) begin
                parity_err <= 1'b0;
                trunc_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: queue-based FIFO source, expected-beat and expected-result scoreboards.
module tb_router_port_rx;

    localparam int BUF_DEPTH = 4;
    localparam int TIMEOUT   = 32;

    logic       clock = 1'b0;
    logic       resetn;
    logic       vld_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       pkt_done;
    logic [1:0] pkt_dest;
    logic [5:0] pkt_len;
    logic       parity_err;
    logic       trunc_err;

    always #5 clock = ~clock;

    router_port_rx #(.BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
        .read_enb(read_enb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .pkt_done(pkt_done), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
        .parity_err(parity_err), .trunc_err(trunc_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int reads = 0;
    int last_rd_cyc = 0;
    int done_cyc = 0;
    int rdy_pct = 100;
    int src_pct = 100;
    int accept_budget = -1;
    bit pend = 0;
    bit stall = 0;
    logic [7:0] stall_dat;

    logic [7:0] fifo_q[$];
    logic [8:0] exp_beats[$];
    logic [9:0] exp_done[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs after the falling edge, then observe what the next rising edge will sample.
    task automatic step();
        logic [8:0] e;
        logic [9:0] d;
        @(negedge clock);
        cyc++;
        if (pend) data_out = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
        vld_out = (fifo_q.size() > 0) && ($urandom_range(99) < src_pct);
        if (accept_budget >= 0) m_ready = (accept_budget > 0);
        else                    m_ready = ($urandom_range(99) < rdy_pct);
        #1;
        pend = read_enb;
        if (read_enb) begin
            reads++;
            last_rd_cyc = cyc;
            check("no_overread", fifo_q.size() > 0, 1);
        end
        if (stall) check("hold_while_stalled", {m_valid, m_data}, {1'b1, stall_dat});
        stall     = m_valid && !m_ready;
        stall_dat = m_data;
        if (m_valid && m_ready) begin
            if (accept_budget > 0) accept_budget--;
            if (exp_beats.size() == 0) check("beat_expected", exp_beats.size() != 0, 1);
            else begin
                e = exp_beats.pop_front();
                check("beat_last_data", {m_last, m_data}, e);
            end
        end
        if (pkt_done) begin
            done_cyc = cyc;
            if (exp_done.size() == 0) check("done_expected", exp_done.size() != 0, 1);
            else begin
                d = exp_done.pop_front();
                check("done_dest_len_perr_terr", {pkt_dest, pkt_len, parity_err, trunc_err}, d);
            end
        end
    endtask

    task automatic send_pkt(input logic [5:0] len, input logic [1:0] dest, input bit corrupt);
        logic [7:0] hdr, p, b;
        hdr = {len, dest};
        p   = hdr;
        fifo_q.push_back(hdr);
        for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            p ^= b;
            fifo_q.push_back(b);
            exp_beats.push_back({(i == int'(len) - 1), b});
        end
        fifo_q.push_back(corrupt ? ~p : p);
        exp_done.push_back({dest, len, corrupt, 1'b0});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((fifo_q.size() > 0 || exp_beats.size() > 0 || exp_done.size() > 0 || pend) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, n < budget, 1);
        repeat (4) step();
    endtask

    initial begin
        logic [7:0] b, p;
        resetn   = 1'b0;
        vld_out  = 1'b1;
        m_ready  = 1'b0;
        data_out = 8'h00;
        #12;
        check("rst_ctrl", {read_enb, m_valid, m_last, pkt_done, parity_err, trunc_err}, 0);
        check("rst_dest", pkt_dest, 0);
        check("rst_len", pkt_len, 0);
        check("rst_mdata", m_data, 0);
        vld_out = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // Good packet, full rate
        reads = 0; rdy_pct = 100;
        send_pkt(6'd14, 2'd2, 1'b0);
        drain("t1", 200);
        check("t1_reads", reads, 16);

        // Bad parity
        reads = 0;
        send_pkt(6'd2, 2'd0, 1'b1);
        drain("t2", 100);
        check("t2_reads", reads, 4);

        // Downstream stall: credit limits outstanding bytes
        reads = 0; accept_budget = 0;
        send_pkt(6'd17, 2'd0, 1'b0);
        repeat (20) step();
        check("t3_credit_reads", reads, 1 + BUF_DEPTH);
        check("t3_valid_held", m_valid, 1);
        accept_budget = -1;
        drain("t3", 200);
        check("t3_reads", reads, 19);

        // Truncation: only header + 5 payload bytes ever arrive; 4 accepted, byte 5 stays buffered
        reads = 0; accept_budget = 4;
        p = 8'h42;
        fifo_q.push_back(p);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            exp_beats.push_back({(i == 4), b});
        end
        exp_done.push_back({2'd2, 6'd16, 1'b0, 1'b1});
        begin
            int n = 0;
            while (exp_done.size() > 0 && n < 200) begin step(); n++; end
            check("t4_done_seen", n < 200, 1);
        end
        check("t4_timeout_cycle", done_cyc, last_rd_cyc + 2 + TIMEOUT);
        check("t4_reads", reads, 6);
        accept_budget = -1;
        drain("t4", 100);
        send_pkt(6'd7, 2'd1, 1'b0);
        drain("t4_next", 100);

        // Zero-length packet
        reads = 0;
        send_pkt(6'd0, 2'd0, 1'b0);
        drain("t5", 50);
        check("t5_reads", reads, 2);

        // Asynchronous reset mid-payload
        send_pkt(6'd20, 2'd1, 1'b0);
        begin
            int n = 0;
            while (exp_beats.size() > 14 && n < 60) begin step(); n++; end
            check("t6_midpkt", n < 60, 1);
        end
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_ctrl", {read_enb, m_valid, m_last, pkt_done, parity_err, trunc_err}, 0);
        check("t6_rst_hdr", {pkt_dest, pkt_len}, 0);
        check("t6_rst_mdata", m_data, 0);
        fifo_q.delete(); exp_beats.delete(); exp_done.delete();
        pend = 0; stall = 0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        reads = 0;
        send_pkt(6'd9, 2'd3, 1'b0);
        drain("t6_next", 100);
        check("t6_reads", reads, 11);

        // Random traffic with source gaps and downstream backpressure
        rdy_pct = 70; src_pct = 80;
        repeat (6) begin
            repeat (3) send_pkt(6'($urandom_range(0, 40)), 2'($urandom), ($urandom_range(3) == 0));
            drain("rand", 3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
